uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: byte-oriented UART transmitter with a small transmit FIFO
// and run-time framing/baud configuration.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   wr_data   byte to enqueue
//   wr_valid  enqueue request, taken when wr_ready is high
//   wr_ready  FIFO not full
//   cfg_we    configuration write strobe, honoured only when fully idle
//   cfg_div   new baud divisor; every serial bit lasts cfg_div+1 cycles
//   cfg_mode  [1:0] data bits minus 5, [2] parity enable, [3] odd parity,
//             [4] two stop bits
//   level     FIFO occupancy
//   busy      frame in progress or FIFO non-empty
//   tx        registered serial line, idle high
module uart_tx_param #(
  parameter int                DIV_W      = 16,
  parameter logic [DIV_W-1:0]  DIV_RESET  = 16'h186A,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          cfg_we,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [4:0]                    cfg_mode,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]     MODE_RESET = 5'b00011;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // XOR of the active data bits only; bits at or above the configured
  // word length never influence the parity bit.
  function automatic logic frame_xor(input logic [7:0] data, input logic [4:0] mode);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, mode[1:0]});
    return ^(data & mask);
  endfunction

  state_t            state_q, state_n;
  logic [DIV_W-1:0]  div_q, fdiv_q, fdiv_n;
  logic [4:0]        mode_q, fmode_q, fmode_n;
  logic [DIV_W-1:0]  cnt_q, cnt_n;
  logic [2:0]        bit_q, bit_n;
  logic              stop2_q, stop2_n;
  logic              tx_q, tx_n;
  logic [7:0]        shift_q, shift_n;
  logic              par_q, par_n;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic              push, pop, start;
  logic              bit_done, last_bit;

  assign wr_ready = (level_q < DEPTH_L);
  assign push     = wr_valid && wr_ready;
  assign level    = level_q;
  assign busy     = (state_q != IDLE) || (level_q != '0);
  assign tx       = tx_q;

  // FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Configuration: only accepted with nothing queued or on the wire, so a
  // frame can never see its divisor or mode change underneath it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= DIV_RESET;
      mode_q <= MODE_RESET;
    end else if (cfg_we && (state_q == IDLE) && (level_q == '0)) begin
      div_q  <= cfg_div;
      mode_q <= cfg_mode;
    end
  end

  // Frame FSM: next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    stop2_n  = stop2_q;
    tx_n     = tx_q;
    shift_n  = shift_q;
    par_n    = par_q;
    fdiv_n   = fdiv_q;
    fmode_n  = fmode_q;
    start    = 1'b0;
    pop      = 1'b0;
    bit_done = (cnt_q == fdiv_q);
    last_bit = (bit_q == (3'd4 + {1'b0, fmode_q[1:0]}));

    case (state_q)
      IDLE: begin
        if (level_q != '0) start = 1'b1;
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
          tx_n    = shift_q[0];
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          if (last_bit) begin
            if (fmode_q[2]) begin
              state_n = PARITY;
              tx_n    = par_q ^ fmode_q[3];
            end else begin
              state_n = STOP;
              stop2_n = 1'b0;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = STOP;
          stop2_n = 1'b0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (fmode_q[4] && !stop2_q) begin
            stop2_n = 1'b1;
          end else begin
            state_n = IDLE;
            // Chain straight into the next frame so back-to-back bytes
            // leave no idle bit between stop and start.
            if (level_q != '0) start = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      pop     = 1'b1;
      state_n = START;
      cnt_n   = '0;
      bit_n   = 3'd0;
      stop2_n = 1'b0;
      tx_n    = 1'b0;
      shift_n = mem[rd_ptr_q];
      par_n   = frame_xor(mem[rd_ptr_q], mode_q);
      fdiv_n  = div_q;
      fmode_n = mode_q;
    end
  end

  // Frame FSM: control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      fdiv_q  <= DIV_RESET;
      fmode_q <= MODE_RESET;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      stop2_q <= stop2_n;
      tx_q    <= tx_n;
      fdiv_q  <= fdiv_n;
      fmode_q <= fmode_n;
    end
  end

  // Frame FSM: data registers
  always_ff @(posedge clk) begin
    shift_q <= shift_n;
    par_q   <= par_n;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param covering reset state,
// 8N1 and 7O2 framing, FIFO fill/drop with contiguous frames, gated
// configuration writes and mid-frame reset.
module tb_uart_tx_param;

  logic        clk;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        cfg_we;
  logic [15:0] cfg_div;
  logic [4:0]  cfg_mode;
  logic [2:0]  level;
  logic        busy;
  logic        tx;

  int tests = 0;
  int fails = 0;

  logic [7:0]  b3 [6];
  int          lvl3 [6];
  logic        rdy3 [6];
  logic [49:0] stream;

  uart_tx_param #(
    .DIV_W      (16),
    .DIV_RESET  (16'h186A),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .cfg_we   (cfg_we),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .level    (level),
    .busy     (busy),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [15:0] d, input logic [4:0] m);
    cfg_we   = 1'b1;
    cfg_div  = d;
    cfg_mode = m;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  // pat[0] is the start bit; each bit must sit on tx for 'hold' samples,
  // after which the next edge must return the block to idle.
  task automatic check_frame(input logic [15:0] pat, input int nbits, input int hold, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < hold; c++) begin
        step();
        check(tag, {31'd0, tx}, {31'd0, pat[b]});
      end
    end
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    cfg_we   = 1'b0;
    cfg_div  = 16'd0;
    cfg_mode = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    reset = 1'b0;
    step();

    // 8N1 at divisor 3, byte A5
    configure(16'd3, 5'b00011);
    write_byte(8'hA5);
    check("f1_level", {29'd0, level}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd1);
    check("f1_tx_pre", {31'd0, tx}, 32'd1);
    check_frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, "f1");

    // 7 data bits, odd parity, two stop bits at divisor 1, byte 03
    configure(16'd1, 5'b11110);
    write_byte(8'h03);
    check_frame({5'b0, 3'b111, 7'b0000011, 1'b0}, 11, 2, "f2");

    // Six back-to-back writes at divisor 0; the sixth finds the FIFO full
    configure(16'd0, 5'b00011);
    b3   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    lvl3 = '{1, 1, 2, 3, 4, 4};
    rdy3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    stream = {1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
              1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    for (int i = 0; i < 6; i++) begin
      wr_data  = b3[i];
      wr_valid = 1'b1;
      step();
      check("f3_level_w", {29'd0, level}, lvl3[i]);
      check("f3_ready_w", {31'd0, wr_ready}, {31'd0, rdy3[i]});
      if (i >= 1) check("f3_tx_w", {31'd0, tx}, {31'd0, stream[i-1]});
      else        check("f3_tx_idle", {31'd0, tx}, 32'd1);
    end
    wr_valid = 1'b0;
    for (int n = 7; n <= 51; n++) begin
      step();
      check("f3_tx", {31'd0, tx}, {31'd0, stream[n-2]});
      if (n == 12)      check("f3_level_12", {29'd0, level}, 32'd3);
      else if (n == 22) check("f3_level_22", {29'd0, level}, 32'd2);
      else if (n == 32) check("f3_level_32", {29'd0, level}, 32'd1);
      else if (n == 42) check("f3_level_42", {29'd0, level}, 32'd0);
      if (n == 12) check("f3_ready_12", {31'd0, wr_ready}, 32'd1);
    end
    step();
    check("f3_busy_fall", {31'd0, busy}, 32'd0);
    check("f3_tx_end", {31'd0, tx}, 32'd1);
    check("f3_level_end", {29'd0, level}, 32'd0);

    // Configuration writes while busy are dropped; accepted once idle
    configure(16'd2, 5'b00011);
    write_byte(8'h5A);
    cfg_we  = 1'b1;
    cfg_div = 16'd7;
    check_frame({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 3, "f4a");
    cfg_we = 1'b0;
    write_byte(8'h3C);
    check_frame({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 3, "f4b");
    configure(16'd7, 5'b00011);
    write_byte(8'hFF);
    check_frame({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 8, "f4c");

    // Reset during data bit 3 with another byte queued
    write_byte(8'h00);
    write_byte(8'hF0);
    repeat (34) step();
    check("f5_mid_tx", {31'd0, tx}, 32'd0);
    check("f5_mid_level", {29'd0, level}, 32'd1);
    check("f5_mid_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("f5_rst_tx", {31'd0, tx}, 32'd1);
    check("f5_rst_level", {29'd0, level}, 32'd0);
    check("f5_rst_busy", {31'd0, busy}, 32'd0);
    check("f5_rst_ready", {31'd0, wr_ready}, 32'd1);
    #1;
    reset = 1'b0;
    step();
    check("f5_post_tx", {31'd0, tx}, 32'd1);
    check("f5_post_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h96);
    check_frame({6'b0, 1'b1, 8'h96, 1'b0}, 10, 6251, "f5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
